// File: rtl/servant_ram_arbiter.sv
// Round-robin arbiter sharing one Wishbone RAM between ibus and dbus.
// Optional ack timeout: define SERVANT_RAM_ARB_TIMEOUT_EN.
module servant_ram_arbiter #(
    parameter int AW      = 30,
    parameter int TIMEOUT = 15
) (
    input  logic          i_wb_clk,
    input  logic          i_wb_rst_n,
    input  logic [31:0]   i_ibus_adr,
    input  logic          i_ibus_cyc,
    output logic [31:0]   o_ibus_rdt,
    output logic          o_ibus_ack,
    input  logic [31:0]   i_dbus_adr,
    input  logic [31:0]   i_dbus_dat,
    input  logic [3:0]    i_dbus_sel,
    input  logic          i_dbus_we,
    input  logic          i_dbus_cyc,
    output logic [31:0]   o_dbus_rdt,
    output logic          o_dbus_ack,
    output logic [AW-1:0] o_wb_adr,
    output logic [31:0]   o_wb_dat,
    output logic [3:0]    o_wb_sel,
    output logic          o_wb_we,
    output logic          o_wb_cyc,
    input  logic [31:0]   i_wb_rdt,
    input  logic          i_wb_ack,
    output logic          o_timeout
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   tmo_q, tmo_d;
    logic   gnt_i, gnt_d, cyc, tmo_hit;

    assign gnt_i = (state_q == GNT_I);
    assign gnt_d = (state_q == GNT_D);
    assign cyc   = (gnt_i & i_ibus_cyc) | (gnt_d & i_dbus_cyc);

`ifdef SERVANT_RAM_ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;

    assign cnt_d   = (gnt_i | gnt_d) ? cnt_q + 8'd1 : 8'd0;
    assign tmo_hit = cyc & ~i_wb_ack & (cnt_q == 8'(TIMEOUT - 1));

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) cnt_q <= 8'd0;
        else             cnt_q <= cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // last_q = 1 means dbus was granted most recently
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        unique case (state_q)
            IDLE: begin
                if (i_ibus_cyc && (!i_dbus_cyc || last_q)) begin
                    state_d = GNT_I;
                    last_d  = 1'b0;
                end else if (i_dbus_cyc) begin
                    state_d = GNT_D;
                    last_d  = 1'b1;
                end
            end
            GNT_I, GNT_D: begin
                if (!cyc || i_wb_ack) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
        if (!i_wb_rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        o_wb_adr = '0;
        o_wb_dat = '0;
        o_wb_sel = '0;
        o_wb_we  = 1'b0;
        unique case (1'b1)
            gnt_i: begin
                o_wb_adr = i_ibus_adr[AW+1:2];
                o_wb_sel = 4'hF;
            end
            gnt_d: begin
                o_wb_adr = i_dbus_adr[AW+1:2];
                o_wb_dat = i_dbus_dat;
                o_wb_sel = i_dbus_sel;
                o_wb_we  = i_dbus_we;
            end
            default: ;
        endcase
    end

    assign o_wb_cyc   = cyc;
    // late acks after the master dropped cyc are swallowed by the cyc gate
    assign o_ibus_ack = gnt_i & i_ibus_cyc & (i_wb_ack | tmo_hit);
    assign o_dbus_ack = gnt_d & i_dbus_cyc & (i_wb_ack | tmo_hit);
    assign o_ibus_rdt = (gnt_i & i_ibus_cyc & i_wb_ack) ? i_wb_rdt : 32'h0;
    assign o_dbus_rdt = (gnt_d & i_dbus_cyc & i_wb_ack) ? i_wb_rdt : 32'h0;
    assign o_timeout  = tmo_q;

    logic unused_adr;
    assign unused_adr = ^{i_ibus_adr, i_dbus_adr};

endmodule

// File: tb/tb_servant_ram_arbiter.sv
// Self-checking bench for servant_ram_arbiter with a behavioural RAM
// and a shadow-memory reference model.
module tb_servant_ram_arbiter;

    localparam int AW  = 30;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   ibus_adr = '0;
    logic          ibus_cyc = 1'b0;
    logic [31:0]   ibus_rdt;
    logic          ibus_ack;
    logic [31:0]   dbus_adr = '0;
    logic [31:0]   dbus_dat = '0;
    logic [3:0]    dbus_sel = '0;
    logic          dbus_we = 1'b0;
    logic          dbus_cyc = 1'b0;
    logic [31:0]   dbus_rdt;
    logic          dbus_ack;
    logic [AW-1:0] wb_adr;
    logic [31:0]   wb_dat;
    logic [3:0]    wb_sel;
    logic          wb_we;
    logic          wb_cyc;
    logic [31:0]   wb_rdt;
    logic          wb_ack;
    logic          timeout;

    logic          ram_ack;
    logic          mute = 1'b0;
    logic          stray = 1'b0;
    logic          load = 1'b0;
    logic [31:0]   mem [0:255];
    logic [31:0]   init_mem [0:255];
    logic [31:0]   ref_mem [0:255];

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    servant_ram_arbiter #(.AW(AW), .TIMEOUT(TMO)) dut (
        .i_wb_clk   (clk),
        .i_wb_rst_n (rst_n),
        .i_ibus_adr (ibus_adr),
        .i_ibus_cyc (ibus_cyc),
        .o_ibus_rdt (ibus_rdt),
        .o_ibus_ack (ibus_ack),
        .i_dbus_adr (dbus_adr),
        .i_dbus_dat (dbus_dat),
        .i_dbus_sel (dbus_sel),
        .i_dbus_we  (dbus_we),
        .i_dbus_cyc (dbus_cyc),
        .o_dbus_rdt (dbus_rdt),
        .o_dbus_ack (dbus_ack),
        .o_wb_adr   (wb_adr),
        .o_wb_dat   (wb_dat),
        .o_wb_sel   (wb_sel),
        .o_wb_we    (wb_we),
        .o_wb_cyc   (wb_cyc),
        .i_wb_rdt   (wb_rdt),
        .i_wb_ack   (wb_ack),
        .o_timeout  (timeout)
    );

    // Single-port RAM: registered read, ack one cycle after cyc
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) ram_ack <= 1'b0;
        else        ram_ack <= wb_cyc & ~ram_ack;
    end

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_mem[i];
        end else begin
            wb_rdt <= mem[wb_adr[7:0]];
            if (rst_n && wb_cyc && wb_we && !ram_ack)
                for (int b = 0; b < 4; b++)
                    if (wb_sel[b]) mem[wb_adr[7:0]][8*b+:8] <= wb_dat[8*b+:8];
        end
    end

    assign wb_ack = (ram_ack & ~mute) | stray;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_write(int a, logic [31:0] d, logic [3:0] s);
        for (int b = 0; b < 4; b++)
            if (s[b]) ref_mem[a][8*b+:8] = d[8*b+:8];
    endfunction

    task automatic xact(input bit is_d, input logic [31:0] adr,
                        input logic [31:0] dat, input logic [3:0] sel,
                        input bit we, output bit got, output int lat,
                        output logic [31:0] rdt, output bit other);
        got = 1'b0; lat = -1; rdt = '0; other = 1'b0;
        if (is_d) begin
            dbus_adr = adr; dbus_dat = dat; dbus_sel = sel;
            dbus_we = we; dbus_cyc = 1'b1;
        end else begin
            ibus_adr = adr; ibus_cyc = 1'b1;
        end
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (is_d ? ibus_ack : dbus_ack) other = 1'b1;
            if (is_d ? dbus_ack : ibus_ack) begin
                got = 1'b1;
                lat = c;
                rdt = is_d ? dbus_rdt : ibus_rdt;
            end
            @(posedge clk); #1;
        end
        ibus_cyc = 1'b0; dbus_cyc = 1'b0; dbus_we = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ibus_cyc = 1'b0; dbus_cyc = 1'b0; dbus_we = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 256; i++) init_mem[i] = $urandom;
        init_mem[0]  = 32'h40000537;
        init_mem[16] = 32'h0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_mem[i];
        load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({wb_cyc, ibus_ack, dbus_ack, wb_we, timeout} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000",
                     {wb_cyc, ibus_ack, dbus_ack, wb_we, timeout});
        end
        n_cmp++;
        if ({wb_adr, wb_dat, wb_sel, ibus_rdt, dbus_rdt} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: adr %h dat %h sel %h irdt %h drdt %h",
                     wb_adr, wb_dat, wb_sel, ibus_rdt, dbus_rdt);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_first_read();
        bit seen_d = 1'b0;
        ibus_adr = 32'h0; ibus_cyc = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (dbus_ack) seen_d = 1'b1;
            n_cmp++;
            if (wb_cyc !== (c >= 1) || ibus_ack !== (c == 2)) begin
                n_fail++;
                $display("FAIL first_read_c%0d: cyc %b ack %b", c, wb_cyc, ibus_ack);
            end
            if (c == 2) begin
                n_cmp++;
                if (ibus_rdt !== ref_mem[0]) begin
                    n_fail++;
                    $display("FAIL first_read_rdt: got %h want %h", ibus_rdt, ref_mem[0]);
                end
            end
            @(posedge clk); #1;
        end
        ibus_cyc = 1'b0;
        n_cmp++;
        if (seen_d) begin
            n_fail++;
            $display("FAIL first_read_dack: got 1 want 0");
        end
    endtask

    task automatic test_write();
        bit got, oth; int lat; logic [31:0] rd;
        dbus_adr = 32'h40; dbus_dat = 32'hA5A5A5A5;
        dbus_sel = 4'b0011; dbus_we = 1'b1; dbus_cyc = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (wb_adr !== 30'h10 || wb_we !== 1'b1 || wb_sel !== 4'b0011 ||
            wb_dat !== 32'hA5A5A5A5 || wb_cyc !== 1'b1) begin
            n_fail++;
            $display("FAIL write_bus: adr %h we %b sel %b dat %h cyc %b",
                     wb_adr, wb_we, wb_sel, wb_dat, wb_cyc);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (dbus_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ack: got %b want 1", dbus_ack);
        end
        @(posedge clk); #1;
        dbus_cyc = 1'b0; dbus_we = 1'b0;
        model_write(16, 32'hA5A5A5A5, 4'b0011);
        xact(1'b0, 32'h40, '0, '0, 1'b0, got, lat, rd, oth);
        n_cmp++;
        if (!got || rd !== ref_mem[16] || rd !== 32'h0000A5A5) begin
            n_fail++;
            $display("FAIL write_readback: got %h want %h", rd, ref_mem[16]);
        end
    endtask

    task automatic test_random();
        bit got, oth, is_d, we; int lat, a;
        logic [31:0] rd, d; logic [3:0] s;
        for (int k = 0; k < 40; k++) begin
            is_d = 1'($urandom);
            we   = is_d & 1'($urandom);
            a    = $urandom_range(1, 255);
            d    = $urandom;
            s    = 4'($urandom);
            xact(is_d, 32'(a) << 2, d, s, we, got, lat, rd, oth);
            n_cmp++;
            if (!got || lat != 2 || oth || rd !== ref_mem[a]) begin
                n_fail++;
                $display("FAIL random_%0d: got %b lat %0d other %b rdt %h want %h",
                         k, got, lat, oth, rd, ref_mem[a]);
            end
            if (we) model_write(a, d, s);
        end
    endtask

    task automatic test_back_to_back();
        int ni = 0, nd = 0;
        bit ei, ed;
        do_reset();
        ibus_adr = 32'd5 << 2; dbus_adr = 32'd9 << 2;
        dbus_we = 1'b0; dbus_sel = 4'hF;
        ibus_cyc = 1'b1; dbus_cyc = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            // grant k spans cycles 3k..3k+2, ibus first, then alternating
            ei = (c < 12) && (c % 3 == 2) && ((c / 3) % 2 == 0);
            ed = (c < 12) && (c % 3 == 2) && ((c / 3) % 2 == 1);
            if (ibus_ack) ni++;
            if (dbus_ack) nd++;
            n_cmp++;
            if (ibus_ack !== ei || dbus_ack !== ed) begin
                n_fail++;
                $display("FAIL b2b_c%0d: iack %b dack %b want %b %b",
                         c, ibus_ack, dbus_ack, ei, ed);
            end
            if (ei) begin
                n_cmp++;
                if (ibus_rdt !== ref_mem[5] || dbus_rdt !== 32'h0) begin
                    n_fail++;
                    $display("FAIL b2b_irdt_c%0d: got %h want %h", c, ibus_rdt, ref_mem[5]);
                end
            end
            if (ed) begin
                n_cmp++;
                if (dbus_rdt !== ref_mem[9] || ibus_rdt !== 32'h0) begin
                    n_fail++;
                    $display("FAIL b2b_drdt_c%0d: got %h want %h", c, dbus_rdt, ref_mem[9]);
                end
            end
            @(posedge clk); #1;
            if (c == 11) begin ibus_cyc = 1'b0; dbus_cyc = 1'b0; end
        end
        n_cmp++;
        if (ni != 2 || nd != 2) begin
            n_fail++;
            $display("FAIL b2b_count: ibus %0d dbus %0d want 2 2", ni, nd);
        end
    endtask

    task automatic test_reset_mid();
        bit got, oth; int lat; logic [31:0] rd;
        dbus_adr = 32'd7 << 2; dbus_we = 1'b0; dbus_cyc = 1'b1;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (wb_cyc !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_gnt: cyc %b want 1", wb_cyc);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dbus_ack !== 1'b0 || wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_drop: dack %b cyc %b want 0 0", dbus_ack, wb_cyc);
        end
        @(posedge clk); #1 dbus_cyc = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dbus_ack !== 1'b0 || wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_hold: dack %b cyc %b want 0 0", dbus_ack, wb_cyc);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        xact(1'b0, 32'd3 << 2, '0, '0, 1'b0, got, lat, rd, oth);
        n_cmp++;
        if (!got || lat != 2 || oth || rd !== ref_mem[3]) begin
            n_fail++;
            $display("FAIL rstmid_after: got %b lat %0d rdt %h want %h",
                     got, lat, rd, ref_mem[3]);
        end
    endtask

    task automatic test_stray();
        bit got, oth; int lat; logic [31:0] rd;
        stray = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ibus_ack !== 1'b0 || dbus_ack !== 1'b0 || wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ack: iack %b dack %b cyc %b want 0 0 0",
                     ibus_ack, dbus_ack, wb_cyc);
        end
        @(posedge clk); #1 stray = 1'b0;
        xact(1'b0, 32'd12 << 2, '0, '0, 1'b0, got, lat, rd, oth);
        n_cmp++;
        if (!got || lat != 2 || oth || rd !== ref_mem[12]) begin
            n_fail++;
            $display("FAIL stray_after: got %b lat %0d rdt %h want %h",
                     got, lat, rd, ref_mem[12]);
        end
    endtask

    task automatic test_abort();
        bit got, oth; int lat; logic [31:0] rd;
        dbus_adr = 32'd20 << 2; dbus_we = 1'b0; dbus_cyc = 1'b1;
        repeat (2) begin @(negedge clk); @(posedge clk); #1; end
        dbus_cyc = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (dbus_ack !== 1'b0 || wb_cyc !== 1'b0 || wb_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_late_ack: dack %b cyc %b slave_ack %b want 0 0 1",
                     dbus_ack, wb_cyc, wb_ack);
        end
        @(posedge clk); #1;
        xact(1'b0, 32'd21 << 2, '0, '0, 1'b0, got, lat, rd, oth);
        n_cmp++;
        if (!got || lat != 2 || oth || rd !== ref_mem[21]) begin
            n_fail++;
            $display("FAIL abort_after: got %b lat %0d rdt %h want %h",
                     got, lat, rd, ref_mem[21]);
        end
    endtask

    task automatic test_timeout();
        bit got, oth; int lat; logic [31:0] rd;
        mute = 1'b1;
        dbus_adr = 32'd30 << 2; dbus_we = 1'b0; dbus_cyc = 1'b1;
`ifdef SERVANT_RAM_ARB_TIMEOUT_EN
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dbus_ack !== (c == TMO) || timeout !== (c > TMO)) begin
                n_fail++;
                $display("FAIL timeout_c%0d: dack %b tmo %b want %b %b",
                         c, dbus_ack, timeout, (c == TMO), (c > TMO));
            end
            if (c == TMO) begin
                n_cmp++;
                if (dbus_rdt !== 32'h0) begin
                    n_fail++;
                    $display("FAIL timeout_rdt: got %h want 0", dbus_rdt);
                end
            end
            @(posedge clk); #1;
            if (c == TMO) dbus_cyc = 1'b0;
        end
        mute = 1'b0;
        xact(1'b0, 32'd31 << 2, '0, '0, 1'b0, got, lat, rd, oth);
        n_cmp++;
        if (!got || rd !== ref_mem[31] || timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: got %b rdt %h tmo %b want %h 1",
                     got, rd, timeout, ref_mem[31]);
        end
`else
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_cmp++;
            if (dbus_ack !== 1'b0 || timeout !== 1'b0 || wb_cyc !== (c >= 1)) begin
                n_fail++;
                $display("FAIL wait_c%0d: dack %b tmo %b cyc %b", c, dbus_ack, timeout, wb_cyc);
            end
            @(posedge clk); #1;
        end
        dbus_cyc = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wb_cyc !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_abort: cyc %b want 0", wb_cyc);
        end
        @(posedge clk); #1 mute = 1'b0;
        xact(1'b0, 32'd31 << 2, '0, '0, 1'b0, got, lat, rd, oth);
        n_cmp++;
        if (!got || lat != 2 || rd !== ref_mem[31]) begin
            n_fail++;
            $display("FAIL wait_after: got %b lat %0d rdt %h want %h",
                     got, lat, rd, ref_mem[31]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_first_read();
        test_write();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_stray();
        test_abort();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
